iq_normalizer_pipe: RTL
=======================

// Module: iq_normalizer_pipe
// PURPOSE
//  Parametrised successor of the fixed two-channel I/Q normalizer.
//  Per channel it computes: y = sat_OUT_W((x + offset[ch]) * gain[ch] >>> SHIFT).
//  Offsets and gains are runtime-programmable through double-buffered shadow/active registers.
//  Adds valid qualification, saturation and sticky overflow flags.
//  Sits between the accumulator and the NN input; out_start is the NN start trigger, aligned to the data.
// PARAMETERS
//  N_CH        2        number of independent channels (I,Q,...), >=1
//  IN_W        32       signed input sample width per channel
//  OUT_W       18       signed output sample width per channel
//  COEF_W      24       signed gain width; COEF_W <= IN_W
//  SHIFT       19       right-shift applied after the multiply, >=1
//  OFFSET_INIT 262143   reset value of every offset register (active and shadow)
//  GAIN_INIT   524288   reset value of every gain register (2^SHIFT = unity)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            input sample valid; no backpressure
//  in_start   in   1            frame-start marker; qualified by in_valid
//  in_data    in   N_CH*IN_W    channel ch at bits [ch*IN_W +: IN_W], signed
//  cfg_we     in   1            write the shadow coefficient selected by cfg_ch/cfg_sel
//  cfg_ch     in   CH_AW        channel index; CH_AW = max(1,$clog2(N_CH))
//  cfg_sel    in   1            0 = offset (IN_W bits), 1 = gain (cfg_data[COEF_W-1:0])
//  cfg_data   in   IN_W         coefficient value, signed
//  cfg_commit in   1            copy all shadow coefficients to active
//  ovf_clr    in   1            clear all sticky overflow flags
//  out_valid  out  1            output sample valid
//  out_start  out  1            in_start delayed with the sample
//  out_data   out  N_CH*OUT_W   channel ch at [ch*OUT_W +: OUT_W], signed
//  ovf        out  N_CH         sticky per-channel saturation flag
// BEHAVIOUR
//  - Reset (async, any time, including mid-stream):
//    - out_valid, out_start, out_data, ovf and all pipeline valids go to 0 immediately.
//    - Active and shadow coefficients return to OFFSET_INIT / GAIN_INIT.
//  - Pipeline: fixed latency of 5 cycles; an in_valid sample at edge N gives out_valid at edge N+5.
//    - S1: s = sx(x) + offset, IN_W+1 bits, never wraps.
//    - S2/S3: p = s * gain, IN_W+1+COEF_W bits, full precision, registered twice.
//    - S4: q = p >>> SHIFT (arithmetic), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    - S5: output register.
//  - Gaps: when in_valid=0, the bubble propagates as out_valid=0.
//    - out_data holds its last valid value during bubbles.
//  - out_start = in_start & in_valid, delayed 5 cycles in lockstep with out_valid.
//    - out_start is never 1 while out_valid is 0.
//  - Config:
//    - cfg_we writes shadow only; active values are unchanged until commit.
//    - A sample accepted in the same cycle as cfg_commit uses the OLD active values.
//      The sample in the next cycle uses the new ones.
//    - cfg_we and cfg_commit in the same cycle: the commit copies the pre-write shadow.
//      The new write reaches active on the next commit.
//    - cfg_ch >= N_CH: the write is ignored.
//  - Overflow flags:
//    - ovf[ch] sets in the cycle out_data[ch] is a saturated valid value.
//    - ovf[ch] stays set until ovf_clr.
//    - Set and ovf_clr in the same cycle: the flag ends set (set wins).
//  - The datapath is identical for every channel; channels never interact.
// CONFIGURATION
//  NORM_ROUND_EN defined:
//    - S4 adds 2^(SHIFT-1) to p before the shift (round half up).
//    - Saturation is applied after rounding.
//  NORM_ROUND_EN undefined:
//    - Plain arithmetic shift (floor).
//  Latency is 5 cycles in both builds.
// TESTING
//  1. Defaults, in_data ch0=-262143, ch1=0, one in_valid pulse.
//     -> 5 cycles later: out_valid=1 for 1 cycle; ch0=0, ch1 saturated to 131071; ovf=2'b10.
//  2. Commit offset=0, gain=2^19; stream x=100,-100,131071,-131072 back to back.
//     -> outputs 100,-100,131071,-131072 on 4 consecutive cycles; ovf unchanged.
//  3. Offset=0, gain=2^18, x=3 then x=-3.
//     -> NORM_ROUND_EN off: 1, -2.
//     -> NORM_ROUND_EN on: 2, -1.
//  4. Gain written 2^18 via cfg_we; cfg_commit coincident with x=10, then x=10 next cycle.
//     -> outputs 10 then 5.
//  5. Sample with in_start=1, then 2 bubbles, then 1 sample.
//     -> out_start=1 only with the first output; out_valid pattern 1,0,0,1.
//  6. Assert rst during a burst of 3 samples.
//     -> out_valid/ovf go 0 at once; no output appears after release.
//     -> coefficients read back as defaults (test 1 result repeats).

Source files
------------

// File: rtl/iq_normalizer_pipe.sv
// iq_normalizer_pipe: per-channel y = sat((x + offset) * gain >>> SHIFT), 5-stage pipeline.
// Optional feature macro NORM_ROUND_EN: round half up before the shift (default: floor).
module iq_normalizer_pipe #(
    parameter int N_CH        = 2,
    parameter int IN_W        = 32,
    parameter int OUT_W       = 18,
    parameter int COEF_W      = 24,
    parameter int SHIFT       = 19,
    parameter int OFFSET_INIT = 262143,
    parameter int GAIN_INIT   = 524288,
    localparam int CH_AW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_start,
    input  logic [N_CH*IN_W-1:0]  in_data,
    input  logic                  cfg_we,
    input  logic [CH_AW-1:0]      cfg_ch,
    input  logic                  cfg_sel,
    input  logic [IN_W-1:0]       cfg_data,
    input  logic                  cfg_commit,
    input  logic                  ovf_clr,
    output logic                  out_valid,
    output logic                  out_start,
    output logic [N_CH*OUT_W-1:0] out_data,
    output logic [N_CH-1:0]       ovf
);

    localparam int S_W = IN_W + 1;
    localparam int P_W = S_W + COEF_W;
    localparam int R_W = P_W + 1;

    localparam logic signed [R_W-1:0] Q_MAX =
        {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] Q_MIN =
        {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0]   off_sh   [N_CH];
    logic signed [IN_W-1:0]   off_act  [N_CH];
    logic signed [COEF_W-1:0] gain_sh  [N_CH];
    logic signed [COEF_W-1:0] gain_act [N_CH];

    logic                     v1, v2, v3, v4;
    logic                     st1, st2, st3, st4;
    logic signed [S_W-1:0]    s1  [N_CH];
    logic signed [COEF_W-1:0] g1  [N_CH];
    logic signed [P_W-1:0]    p2  [N_CH];
    logic signed [P_W-1:0]    p3  [N_CH];
    logic signed [R_W-1:0]    r4  [N_CH];
    logic [N_CH-1:0]          hi4;
    logic [N_CH-1:0]          lo4;
    logic [OUT_W-1:0]         q4  [N_CH];
    logic [N_CH-1:0]          sat4;

    // Shadow writes and shadow-to-active commit; commit sees pre-write shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                off_sh[c]   <= IN_W'(OFFSET_INIT);
                off_act[c]  <= IN_W'(OFFSET_INIT);
                gain_sh[c]  <= COEF_W'(GAIN_INIT);
                gain_act[c] <= COEF_W'(GAIN_INIT);
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_we && int'(cfg_ch) == c) begin
                    unique case (1'b1)
                        cfg_sel:  gain_sh[c] <= cfg_data[COEF_W-1:0];
                        !cfg_sel: off_sh[c]  <= cfg_data;
                    endcase
                end
                if (cfg_commit) begin
                    off_act[c]  <= off_sh[c];
                    gain_act[c] <= gain_sh[c];
                end
            end
        end
    end

    // Valid and frame-start markers travel in lockstep with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {v1, v2, v3, v4} <= '0;
            {st1, st2, st3, st4} <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            st1       <= in_start & in_valid;
            st2       <= st1;
            st3       <= st2;
            st4       <= st3;
            out_start <= st4;
        end
    end

    // Gain is captured with the sample so a same-cycle commit cannot affect it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                s1[c] <= '0;
                g1[c] <= '0;
                p2[c] <= '0;
                p3[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                s1[c] <= S_W'($signed(in_data[c*IN_W +: IN_W]))
                       + S_W'(off_act[c]);
                g1[c] <= gain_act[c];
                p2[c] <= P_W'(s1[c]) * P_W'(g1[c]);
                p3[c] <= p2[c];
            end
        end
    end

    // Optional rounding, arithmetic shift and range compare
    always_comb begin
        hi4 = '0;
        lo4 = '0;
        for (int c = 0; c < N_CH; c++) begin
`ifdef NORM_ROUND_EN
            r4[c] = (R_W'(p3[c]) + (R_W'(1) <<< (SHIFT - 1))) >>> SHIFT;
`else
            r4[c] = R_W'(p3[c]) >>> SHIFT;
`endif
            hi4[c] = r4[c] > Q_MAX;
            lo4[c] = r4[c] < Q_MIN;
        end
    end

    // Saturation stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat4 <= '0;
            for (int c = 0; c < N_CH; c++) q4[c] <= '0;
        end else begin
            sat4 <= hi4 | lo4;
            for (int c = 0; c < N_CH; c++) begin
                if (hi4[c])
                    q4[c] <= Q_MAX[OUT_W-1:0];
                else if (lo4[c])
                    q4[c] <= Q_MIN[OUT_W-1:0];
                else
                    q4[c] <= r4[c][OUT_W-1:0];
            end
        end
    end

    // Output register holds through bubbles; sticky flags, set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            ovf      <= '0;
        end else begin
            if (v4) begin
                for (int c = 0; c < N_CH; c++)
                    out_data[c*OUT_W +: OUT_W] <= q4[c];
            end
            ovf <= (ovf & ~{N_CH{ovf_clr}}) | (sat4 & {N_CH{v4}});
        end
    end

endmodule
